// File: rtl/ct_lsu_dcache_pkg.sv
// ----------------------------------------------------------------------------
// ct_lsu_dcache_pkg
//   Shared types and helpers for the LSU dcache data bank.
//   - dcache_state_e : bank FSM encoding (IDLE / INIT zero-fill)
//   - byte_par()     : even parity of one byte (used when the bank is built
//                      with DCACHE_DATA_PARITY_EN)
// ----------------------------------------------------------------------------
package ct_lsu_dcache_pkg;

    typedef enum logic {
        DC_IDLE = 1'b0,
        DC_INIT = 1'b1
    } dcache_state_e;

    // Even parity: the stored bit makes the 9-bit {par, byte} group even.
    function automatic logic byte_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ct_lsu_dcache_data_ram.sv
// ----------------------------------------------------------------------------
// ct_lsu_dcache_data_ram
//   Behavioural single-port RAM organised as NUM_LANES lanes of LANE_W bits.
//   Each lane has its own write enable. Reads are registered: dout_o updates
//   only on a read and otherwise holds the last read word.
//
// Ports
//   clk_i   : RAM clock (gated by the parent)
//   ce_i    : access enable
//   we_i    : 1 = write lanes selected by be_i, 0 = read
//   idx_i   : entry index
//   be_i    : per-lane write enable
//   din_i   : write data, lane-packed
//   dout_o  : registered read data, lane-packed
// ----------------------------------------------------------------------------
module ct_lsu_dcache_data_ram #(
    parameter int NUM_LANES = 8,
    parameter int LANE_W    = 8,
    parameter int DEPTH     = 2048,
    parameter int IDX_WIDTH = $clog2(DEPTH)
) (
    input  logic                                clk_i,
    input  logic                                ce_i,
    input  logic                                we_i,
    input  logic [IDX_WIDTH-1:0]                idx_i,
    input  logic [NUM_LANES-1:0]                be_i,
    input  logic [NUM_LANES-1:0][LANE_W-1:0]    din_i,
    output logic [NUM_LANES-1:0][LANE_W-1:0]    dout_o
);

    logic [NUM_LANES-1:0][LANE_W-1:0] mem_q [DEPTH];
    logic [NUM_LANES-1:0][LANE_W-1:0] dout_q;

    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            if (we_i) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (be_i[i]) begin
                        mem_q[idx_i][i] <= din_i[i];
                    end
                end
            end else begin
                dout_q <= mem_q[idx_i];
            end
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/gated_clk_cell.sv
// ----------------------------------------------------------------------------
// gated_clk_cell
//   Behavioural model of the standard latch-based clock gate.
//   Clock runs when (global_en & (module_en | local_en)) | external_en,
//   or unconditionally in scan mode. The enable is captured while clk_in
//   is low so clk_out never glitches.
//
// Ports
//   clk_in, global_en, module_en, local_en, external_en,
//   pad_yy_icg_scan_en : inputs as named
//   clk_out            : gated clock
// ----------------------------------------------------------------------------
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic clk_en_bf_latch;
    logic clk_en_lat;

    assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

    always_latch begin
        if (!clk_in) begin
            clk_en_lat <= clk_en_bf_latch | pad_yy_icg_scan_en;
        end
    end

    assign clk_out = clk_in & clk_en_lat;

endmodule

// File: rtl/ct_lsu_dcache_data_bank.sv
// ----------------------------------------------------------------------------
// ct_lsu_dcache_data_bank
//   One dcache data bank: byte-write-enabled single-port storage with a
//   1-cycle registered read return and a zero-fill engine that runs after
//   reset or on init_req.
//
// Optional feature (macro DCACHE_DATA_PARITY_EN): one even-parity bit per
//   byte is stored and checked on every read return (rd_perr).
//
// Ports
//   forever_cpuclk     : free-running clock
//   cpurst             : synchronous active-high reset
//   pad_yy_icg_scan_en : ICG scan enable
//   cp0_lsu_icg_en     : ICG module enable
//   init_req / init_busy : start / status of the zero-fill
//   req_vld/req_rdy/req_wr/req_idx/req_be/req_din : access request
//   rd_vld / rd_data   : read return (rd_data holds until next return)
//   rd_perr            : per-byte parity error (parity build only)
// ----------------------------------------------------------------------------
module ct_lsu_dcache_data_bank
    import ct_lsu_dcache_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 2048,
    parameter int IDX_WIDTH  = $clog2(DEPTH),
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  pad_yy_icg_scan_en,
    input  logic                  cp0_lsu_icg_en,
    input  logic                  init_req,
    output logic                  init_busy,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [IDX_WIDTH-1:0]  req_idx,
    input  logic [BE_WIDTH-1:0]   req_be,
    input  logic [DATA_WIDTH-1:0] req_din,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data
`ifdef DCACHE_DATA_PARITY_EN
   ,output logic [BE_WIDTH-1:0]   rd_perr
`endif
);

`ifdef DCACHE_DATA_PARITY_EN
    localparam int LANE_W = 9;   // {parity, byte}
`else
    localparam int LANE_W = 8;
`endif

    dcache_state_e               state_q, state_d;
    logic [IDX_WIDTH-1:0]        init_cnt_q, init_cnt_d;
    logic                        rd_vld_q;
    logic                        rd_seen_q;   // a read has returned since reset

    logic                        req_acc;
    logic                        rd_acc;
    logic                        init_last;

    logic                        ram_clk;
    logic                        ram_ce;
    logic                        ram_we;
    logic [IDX_WIDTH-1:0]        ram_idx;
    logic [BE_WIDTH-1:0]         ram_be;
    logic [BE_WIDTH-1:0][LANE_W-1:0] ram_din;
    logic [BE_WIDTH-1:0][LANE_W-1:0] ram_dout;
    logic                        icg_local_en;

    assign req_acc   = req_vld & req_rdy;
    assign rd_acc    = req_acc & ~req_wr;
    assign init_last = (init_cnt_q == IDX_WIDTH'(DEPTH - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q    <= DC_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // init_req is only looked at in IDLE, so a request mid-fill is dropped.
    // The counter wraps to 0 on the last fill write since DEPTH is a power
    // of two.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            DC_IDLE: if (init_req) state_d = DC_INIT;
            DC_INIT: begin
                init_cnt_d = init_cnt_q + IDX_WIDTH'(1);
                if (init_last) state_d = DC_IDLE;
            end
            default: state_d = DC_INIT;
        endcase
    end

    // ---------------- FSM: outputs / RAM control ----------------
    always_comb begin
        init_busy = (state_q == DC_INIT);
        req_rdy   = (state_q == DC_IDLE) & ~init_req;
        ram_ce    = (init_busy | req_acc) & ~cpurst;
        ram_we    = init_busy | req_wr;
        ram_idx   = init_busy ? init_cnt_q : req_idx;
        ram_be    = init_busy ? '1 : req_be;
        ram_din   = '0;
        if (!init_busy) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
`ifdef DCACHE_DATA_PARITY_EN
                ram_din[i] = {byte_par(req_din[i*8 +: 8]), req_din[i*8 +: 8]};
`else
                ram_din[i] = req_din[i*8 +: 8];
`endif
            end
        end
    end

    // ---------------- read-valid pipeline ----------------
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            rd_vld_q  <= 1'b0;
            rd_seen_q <= 1'b0;
        end else begin
            rd_vld_q  <= rd_acc;
            rd_seen_q <= rd_seen_q | rd_acc;
        end
    end

    assign rd_vld = rd_vld_q;

    // RAM output register only changes on reads, which gives the hold
    // behaviour; rd_seen_q supplies the zero value after reset.
    always_comb begin
        rd_data = '0;
        if (rd_seen_q) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                rd_data[i*8 +: 8] = ram_dout[i][7:0];
            end
        end
    end

`ifdef DCACHE_DATA_PARITY_EN
    always_comb begin
        rd_perr = '0;
        if (rd_vld_q) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                rd_perr[i] = ram_dout[i][8] ^ byte_par(ram_dout[i][7:0]);
            end
        end
    end
`endif

    // ---------------- clock gate ----------------
    assign icg_local_en = req_acc | init_busy | rd_vld_q;

    gated_clk_cell x_dbank_gated_clk (
        .clk_in             (forever_cpuclk),
        .global_en          (1'b1),
        .module_en          (cp0_lsu_icg_en),
        .local_en           (icg_local_en),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (ram_clk)
    );

    // ---------------- storage ----------------
    ct_lsu_dcache_data_ram #(
        .NUM_LANES (BE_WIDTH),
        .LANE_W    (LANE_W),
        .DEPTH     (DEPTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_ram (
        .clk_i  (ram_clk),
        .ce_i   (ram_ce),
        .we_i   (ram_we),
        .idx_i  (ram_idx),
        .be_i   (ram_be),
        .din_i  (ram_din),
        .dout_o (ram_dout)
    );

endmodule

// File: tb/tb_ct_lsu_dcache_data_bank.sv
module tb_ct_lsu_dcache_data_bank;
    localparam int DW  = 64;
    localparam int DEP = 16;
    localparam int IW  = 4;
    localparam int BW  = 8;

    logic          clk = 1'b0;
    logic          cpurst = 1'b1;
    logic          scan_en = 1'b0;
    logic          icg_en = 1'b0;
    logic          init_req = 1'b0;
    logic          init_busy;
    logic          req_vld = 1'b0;
    logic          req_rdy;
    logic          req_wr = 1'b0;
    logic [IW-1:0] req_idx = '0;
    logic [BW-1:0] req_be = '0;
    logic [DW-1:0] req_din = '0;
    logic          rd_vld;
    logic [DW-1:0] rd_data;
`ifdef DCACHE_DATA_PARITY_EN
    logic [BW-1:0] rd_perr;
    logic [BW-1:0] mdl_bad [DEP];
    logic [BW-1:0] exp_perr;
`endif

    ct_lsu_dcache_data_bank #(.DATA_WIDTH(DW), .DEPTH(DEP)) dut (
        .forever_cpuclk     (clk),
        .cpurst             (cpurst),
        .pad_yy_icg_scan_en (scan_en),
        .cp0_lsu_icg_en     (icg_en),
        .init_req           (init_req),
        .init_busy          (init_busy),
        .req_vld            (req_vld),
        .req_rdy            (req_rdy),
        .req_wr             (req_wr),
        .req_idx            (req_idx),
        .req_be             (req_be),
        .req_din            (req_din),
        .rd_vld             (rd_vld),
        .rd_data            (rd_data)
`ifdef DCACHE_DATA_PARITY_EN
       ,.rd_perr            (rd_perr)
`endif
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // Reference model: contents per entry, remaining fill cycles, pending
    // read-return flag and the value rd_data is expected to show.
    logic [DW-1:0] mdl_mem [DEP];
    int            fill_left;
    bit            pend;
    logic [DW-1:0] hold;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic mdl_zero();
        for (int k = 0; k < DEP; k++) begin
            mdl_mem[k] = '0;
`ifdef DCACHE_DATA_PARITY_EN
            mdl_bad[k] = '0;
`endif
        end
    endtask

    // One clock cycle with the inputs currently driven.
    task automatic tick();
        logic          acc;
        logic [DW-1:0] m;
        #1;
        chk("init_busy", 64'(init_busy), 64'(fill_left > 0));
        chk("req_rdy", 64'(req_rdy), 64'((fill_left == 0) && !init_req));
        acc  = (fill_left == 0) && !init_req && req_vld;
        pend = 1'b0;
        if (cpurst) begin
            fill_left = DEP; hold = '0; mdl_zero();
        end else if (fill_left > 0) begin
            fill_left--;
        end else if (init_req) begin
            fill_left = DEP; mdl_zero();
        end else if (acc && req_wr) begin
            m = '0;
            for (int b = 0; b < BW; b++) if (req_be[b]) m[b*8 +: 8] = 8'hFF;
            mdl_mem[req_idx] = (mdl_mem[req_idx] & ~m) | (req_din & m);
`ifdef DCACHE_DATA_PARITY_EN
            mdl_bad[req_idx] = mdl_bad[req_idx] & ~req_be;
`endif
        end else if (acc) begin
            pend = 1'b1;
            hold = mdl_mem[req_idx];
`ifdef DCACHE_DATA_PARITY_EN
            exp_perr = mdl_bad[req_idx];
`endif
        end
        @(posedge clk); #1;
        chk("rd_vld", 64'(rd_vld), 64'(pend));
        chk("rd_data", rd_data, hold);
`ifdef DCACHE_DATA_PARITY_EN
        chk("rd_perr", 64'(rd_perr), pend ? 64'(exp_perr) : 64'd0);
`endif
    endtask

    task automatic op(input bit wr, input int idx, input logic [DW-1:0] d, input logic [BW-1:0] be);
        req_vld = 1'b1; req_wr = wr; req_idx = IW'(idx); req_din = d; req_be = be;
        tick();
        req_vld = 1'b0;
    endtask

    // Counts cycles with init_busy high; pulses init_req on cycle pulse_at.
    task automatic fill_len(input int pulse_at, output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!init_busy) break;
            init_req = (k == pulse_at);
            n++;
            tick();
        end
        init_req = 1'b0;
    endtask

    initial begin
        int n;
        // reset
        repeat (2) @(posedge clk);
        #1;
        fill_left = DEP; pend = 1'b0; hold = '0; mdl_zero();
        tick();
        cpurst = 1'b0;
        fill_len(-1, n);
        chk("fill_len_reset", 64'(n), 64'd16);

        // all entries read back as zero, back-to-back
        for (int i = 0; i < DEP; i++) op(1'b0, i, '0, '0);
        tick();

        // byte-masked merge
        op(1'b1, 5, 64'h1122334455667788, 8'hFF);
        op(1'b1, 5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        op(1'b0, 5, '0, '0);
        chk("merge_data", rd_data, 64'h11223344AAAAAAAA);
        op(1'b1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);   // no-op write
        op(1'b0, 5, '0, '0);
        chk("be0_noop", rd_data, 64'h11223344AAAAAAAA);

        // back-to-back reads and hold
        op(1'b1, 1, 64'h1, 8'hFF);
        op(1'b1, 2, 64'h2, 8'hFF);
        op(1'b1, 3, 64'h3, 8'hFF);
        op(1'b0, 1, '0, '0);
        op(1'b0, 2, '0, '0);
        op(1'b0, 3, '0, '0);
        repeat (3) tick();
        chk("hold_data", rd_data, 64'h3);

        // init_req with req_vld in IDLE, then again mid-fill
        init_req = 1'b1;
        op(1'b0, 2, '0, '0);
        init_req = 1'b0;
        chk("init_rise", 64'(init_busy), 64'd1);
        fill_len(5, n);
        chk("fill_len_req", 64'(n), 64'd16);

`ifdef DCACHE_DATA_PARITY_EN
        // corrupt one stored data bit of byte 2 at index 7
        dut.u_ram.mem_q[7][2][0] = ~dut.u_ram.mem_q[7][2][0];
        mdl_mem[7][16] = ~mdl_mem[7][16];
        mdl_bad[7] = 8'h04;
        op(1'b0, 7, '0, '0);
        chk("perr_hit", 64'(rd_perr), 64'h04);
        op(1'b0, 8, '0, '0);
        chk("perr_clean", 64'(rd_perr), 64'h00);
`endif

        // randomized traffic including occasional init_req / reset
        for (int c = 0; c < 500; c++) begin
            cpurst   = ($urandom_range(0, 149) == 0);
            init_req = ($urandom_range(0, 79) == 0);
            req_vld  = $urandom_range(0, 3) != 0;
            req_wr   = $urandom_range(0, 1) != 0;
            req_idx  = IW'($urandom_range(0, DEP - 1));
            req_be   = BW'($urandom);
            req_din  = {$urandom, $urandom};
            tick();
        end
        cpurst = 1'b0; init_req = 1'b0; req_vld = 1'b0;
        for (int k = 0; k < 40 && fill_left > 0; k++) tick();

        // reset in the same cycle as an accepted read
        req_vld = 1'b1; req_wr = 1'b0; req_idx = 4'd3; cpurst = 1'b1;
        tick();
        req_vld = 1'b0; cpurst = 1'b0;
        chk("rst_drop_vld", 64'(rd_vld), 64'd0);
        fill_len(-1, n);
        chk("fill_len_rst", 64'(n), 64'd16);

        // reset in the cycle after an accepted read
        op(1'b1, 4, 64'hDEAD_BEEF_0000_0001, 8'hFF);
        op(1'b0, 4, '0, '0);
        cpurst = 1'b1;
        tick();
        cpurst = 1'b0;
        chk("rst_after_vld", 64'(rd_vld), 64'd0);
        chk("rst_data_zero", rd_data, 64'd0);
        fill_len(-1, n);
        chk("fill_len_rst2", 64'(n), 64'd16);
        op(1'b0, 4, '0, '0);
        chk("post_rst_zero", rd_data, 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
